obs_trace_sequencer: RTL and testbench

OBS_TRACE_SEQUENCER -- requirements
Module: obs_trace_sequencer

---
 rtl/obs_trace_sequencer.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_obs_trace_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/obs_trace_sequencer.sv
// obs_trace_sequencer
//
// Captures per-cycle observation records from six trace channels and
// serialises them as single-channel beats on a valid/ready stream.
// Each cycle with at least one asserted cond forms a record: a 6-bit mask
// of the asserted conds plus all six argument values. Records wait in a
// DEPTH-entry FIFO. Within the head record the pending channels are sent
// lowest index first, one beat per handshake. A record that finds the FIFO
// full is dropped whole and the sticky overflow flag is raised.
//
// Optional feature macro: OBS_DROP_CNT_EN. When defined, the block adds a
// 16-bit saturating count of dropped records on drop_cnt.
//
// Ports
//   clock, reset_n              clock, asynchronous active-low reset
//   <c>_obs_src_cond            per-channel observation valid
//   <c>_obs_src_arg0            per-channel value (waddr/raddr 21 bits)
//   out_valid/out_ready         beat handshake
//   out_chan                    channel id (pc=0 .. rdata=5)
//   out_data                    channel value, addresses zero-extended
//   out_last                    final beat of the current record
//   overflow, overflow_clr      sticky drop flag and its clear
//   drop_cnt                    dropped-record count (OBS_DROP_CNT_EN only)

module obs_trace_sequencer #(
    parameter int DEPTH = 4,
    parameter int DW    = 32
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          pc_obs_src_cond,
    input  logic [31:0]   pc_obs_src_arg0,
    input  logic          instr_obs_src_cond,
    input  logic [31:0]   instr_obs_src_arg0,
    input  logic          waddr_obs_src_cond,
    input  logic [20:0]   waddr_obs_src_arg0,
    input  logic          wdata_obs_src_cond,
    input  logic [31:0]   wdata_obs_src_arg0,
    input  logic          raddr_obs_src_cond,
    input  logic [20:0]   raddr_obs_src_arg0,
    input  logic          rdata_obs_src_cond,
    input  logic [31:0]   rdata_obs_src_arg0,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [2:0]    out_chan,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          overflow,
    input  logic          overflow_clr
`ifdef OBS_DROP_CNT_EN
    ,
    output logic [15:0]   drop_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Index of the lowest set bit; the beat order inside a record.
    function automatic logic [2:0] lowest_idx(input logic [5:0] m);
        logic [2:0] idx;
        casez (m)
            6'b?????1: idx = 3'd0;
            6'b????10: idx = 3'd1;
            6'b???100: idx = 3'd2;
            6'b??1000: idx = 3'd3;
            6'b?10000: idx = 3'd4;
            6'b100000: idx = 3'd5;
            default:   idx = 3'd0;
        endcase
        return idx;
    endfunction

    // True when exactly one bit is set: the next beat closes the record.
    function automatic logic single_bit(input logic [5:0] m);
        return (m != 6'd0) && ((m & (m - 6'd1)) == 6'd0);
    endfunction

    // Mask with its lowest set bit removed.
    function automatic logic [5:0] clear_lowest(input logic [5:0] m);
        return m & (m - 6'd1);
    endfunction

    // Record storage
    logic [5:0]    mask_mem_r [DEPTH];
    logic [31:0]   arg_mem_r  [DEPTH][6];

    // Control state
    state_t        state_r;
    state_t        state_nxt_s;
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] cnt_r;
    logic [5:0]    pend_r;
    logic          out_valid_r;
    logic [2:0]    out_chan_r;
    logic [DW-1:0] out_data_r;
    logic          out_last_r;
    logic          overflow_r;

    // Next-state signals
    logic [5:0]    cond_s;
    logic [31:0]   arg_s [6];
    logic          hs_s;
    logic          pop_s;
    logic          any_cond_s;
    logic [CW-1:0] occ_after_pop_s;
    logic          accept_s;
    logic          drop_s;
    logic [CW-1:0] cnt_nxt_s;
    logic [PW-1:0] wr_ptr_nxt_s;
    logic [PW-1:0] rd_ptr_nxt_s;
    logic          head_bypass_s;
    logic [5:0]    pend_nxt_s;
    logic [2:0]    head_idx_s;
    logic [31:0]   head_arg_s;
    logic          valid_nxt_s;
    logic [2:0]    chan_nxt_s;
    logic [DW-1:0] data_nxt_s;
    logic          last_nxt_s;

    assign cond_s = {rdata_obs_src_cond, raddr_obs_src_cond, wdata_obs_src_cond,
                     waddr_obs_src_cond, instr_obs_src_cond, pc_obs_src_cond};

    assign arg_s[0] = pc_obs_src_arg0;
    assign arg_s[1] = instr_obs_src_arg0;
    assign arg_s[2] = {11'd0, waddr_obs_src_arg0};
    assign arg_s[3] = wdata_obs_src_arg0;
    assign arg_s[4] = {11'd0, raddr_obs_src_arg0};
    assign arg_s[5] = rdata_obs_src_arg0;

    // FIFO bookkeeping, head-record pending mask and next output beat.
    always_comb begin
        hs_s            = out_valid_r & out_ready;
        pop_s           = hs_s & out_last_r;
        any_cond_s      = |cond_s;
        // A pop in the same cycle frees a slot for the incoming record.
        occ_after_pop_s = cnt_r - {{PW{1'b0}}, pop_s};
        accept_s        = any_cond_s & (occ_after_pop_s < CW'(DEPTH));
        drop_s          = any_cond_s & ~accept_s;
        cnt_nxt_s       = occ_after_pop_s + {{PW{1'b0}}, accept_s};
        wr_ptr_nxt_s    = accept_s ? (wr_ptr_r + PW'(1)) : wr_ptr_r;
        rd_ptr_nxt_s    = pop_s ? (rd_ptr_r + PW'(1)) : rd_ptr_r;
        // The incoming record becomes head at once when nothing else is stored;
        // its storage slot is written on this same edge, so read the inputs.
        head_bypass_s   = accept_s & (occ_after_pop_s == CW'(0));

        if (head_bypass_s) begin
            pend_nxt_s = cond_s;
        end else if (pop_s && (occ_after_pop_s == CW'(0))) begin
            pend_nxt_s = 6'd0;
        end else if (pop_s) begin
            pend_nxt_s = mask_mem_r[rd_ptr_nxt_s];
        end else if (hs_s) begin
            pend_nxt_s = clear_lowest(pend_r);
        end else begin
            pend_nxt_s = pend_r;
        end

        head_idx_s = lowest_idx(pend_nxt_s);
        if (head_bypass_s) begin
            head_arg_s = arg_s[head_idx_s];
        end else begin
            head_arg_s = arg_mem_r[rd_ptr_nxt_s][head_idx_s];
        end

        if (cnt_nxt_s != CW'(0)) begin
            valid_nxt_s = 1'b1;
            chan_nxt_s  = head_idx_s;
            data_nxt_s  = DW'(head_arg_s);
            last_nxt_s  = single_bit(pend_nxt_s);
        end else begin
            valid_nxt_s = 1'b0;
            chan_nxt_s  = 3'd0;
            data_nxt_s  = {DW{1'b0}};
            last_nxt_s  = 1'b0;
        end
    end

    // Sequencer next state: leave IDLE on the first accepted record, return when drained.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = SEND;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SEND: begin
                if (cnt_nxt_s == CW'(0)) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = SEND;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Record storage write; contents need no reset since occupancy gates use.
    always_ff @(posedge clock) begin
        if (accept_s) begin
            mask_mem_r[wr_ptr_r] <= cond_s;
            for (int c = 0; c < 6; c++) begin
                arg_mem_r[wr_ptr_r][c] <= arg_s[c];
            end
        end
    end

    // State, pointers, occupancy and registered output beat.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            cnt_r       <= {CW{1'b0}};
            pend_r      <= 6'd0;
            out_valid_r <= 1'b0;
            out_chan_r  <= 3'd0;
            out_data_r  <= {DW{1'b0}};
            out_last_r  <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            wr_ptr_r    <= wr_ptr_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
            cnt_r       <= cnt_nxt_s;
            pend_r      <= pend_nxt_s;
            out_valid_r <= (state_nxt_s == SEND);
            out_chan_r  <= chan_nxt_s;
            out_data_r  <= data_nxt_s;
            out_last_r  <= last_nxt_s;
        end
    end

    // Sticky overflow; a drop in the clearing cycle keeps it set.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (overflow_clr) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

`ifdef OBS_DROP_CNT_EN
    logic [15:0] drop_cnt_r;

    // Saturating drop counter; a drop in the clearing cycle restarts it at one.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt_r <= 16'd0;
        end else if (overflow_clr) begin
            drop_cnt_r <= drop_s ? 16'd1 : 16'd0;
        end else if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
            drop_cnt_r <= drop_cnt_r + 16'd1;
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign drop_cnt = drop_cnt_r;
`endif

    assign out_valid = out_valid_r;
    assign out_chan  = out_chan_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_obs_trace_sequencer.sv
// Self-checking bench for obs_trace_sequencer. A reference model keeps the
// expected beat stream as a queue of (chan, data, last) beats plus a record
// count; every step drives inputs at the falling edge, advances the model
// across the rising edge and compares the DUT outputs at the next falling edge.

module tb_obs_trace_sequencer;

    localparam int DEPTH = 4;
    localparam int DW    = 32;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [5:0]    cond_v;
    logic [31:0]   arg_v [6];
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    out_chan;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          overflow;
    logic          overflow_clr;
`ifdef OBS_DROP_CNT_EN
    logic [15:0]   drop_cnt;
`endif

    always #5 clock = ~clock;

    obs_trace_sequencer #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .pc_obs_src_cond    (cond_v[0]),
        .pc_obs_src_arg0    (arg_v[0]),
        .instr_obs_src_cond (cond_v[1]),
        .instr_obs_src_arg0 (arg_v[1]),
        .waddr_obs_src_cond (cond_v[2]),
        .waddr_obs_src_arg0 (arg_v[2][20:0]),
        .wdata_obs_src_cond (cond_v[3]),
        .wdata_obs_src_arg0 (arg_v[3]),
        .raddr_obs_src_cond (cond_v[4]),
        .raddr_obs_src_arg0 (arg_v[4][20:0]),
        .rdata_obs_src_cond (cond_v[5]),
        .rdata_obs_src_arg0 (arg_v[5]),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_chan           (out_chan),
        .out_data           (out_data),
        .out_last           (out_last),
        .overflow           (overflow),
        .overflow_clr       (overflow_clr)
`ifdef OBS_DROP_CNT_EN
        ,
        .drop_cnt           (drop_cnt)
`endif
    );

    typedef struct {
        logic [2:0]  chan;
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t       beat_q[$];
    int          rec_cnt;
    logic        m_ovf;
    logic [15:0] m_dcnt;
    int          n_cmp;
    int          n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        beat_q.delete();
        rec_cnt = 0;
        m_ovf   = 1'b0;
        m_dcnt  = 16'd0;
    endtask

    // One rising edge of the reference behaviour.
    task automatic model_edge(input logic [5:0] cond, input logic rdy, input logic clr);
        logic  drop;
        beat_t b;
        drop = 1'b0;
        if (beat_q.size() > 0 && rdy) begin
            b = beat_q.pop_front();
            if (b.last) rec_cnt--;
        end
        if (cond != 6'd0) begin
            if (rec_cnt < DEPTH) begin
                for (int c = 0; c < 6; c++) begin
                    if (cond[c]) begin
                        b.chan = 3'(c);
                        b.data = (c == 2 || c == 4) ? {11'd0, arg_v[c][20:0]} : arg_v[c];
                        b.last = ((cond >> (c + 1)) == 6'd0);
                        beat_q.push_back(b);
                    end
                end
                rec_cnt++;
            end else begin
                drop = 1'b1;
            end
        end
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (clr) m_dcnt = drop ? 16'd1 : 16'd0;
        else if (drop && m_dcnt != 16'hFFFF) m_dcnt = m_dcnt + 16'd1;
    endtask

    task automatic check_outputs(input string tag);
        if (beat_q.size() > 0) begin
            check({tag, ".valid"}, 32'(out_valid), 32'd1);
            check({tag, ".chan"}, 32'(out_chan), 32'(beat_q[0].chan));
            check({tag, ".data"}, out_data, beat_q[0].data);
            check({tag, ".last"}, 32'(out_last), 32'(beat_q[0].last));
        end else begin
            check({tag, ".valid"}, 32'(out_valid), 32'd0);
        end
        check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
`ifdef OBS_DROP_CNT_EN
        check({tag, ".dcnt"}, 32'(drop_cnt), 32'(m_dcnt));
`endif
    endtask

    task automatic step(input logic [5:0] cond, input logic rdy, input logic clr, input string tag);
        cond_v       = cond;
        out_ready    = rdy;
        overflow_clr = clr;
        model_edge(cond, rdy, clr);
        @(posedge clock);
        @(negedge clock);
        check_outputs(tag);
    endtask

    task automatic rand_args();
        for (int i = 0; i < 6; i++) arg_v[i] = $urandom;
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (beat_q.size() > 0 && guard < 64) begin
            step(6'd0, 1'b1, 1'b0, tag);
            guard++;
        end
        step(6'd0, 1'b1, 1'b0, tag);
    endtask

    initial begin
        n_cmp        = 0;
        n_fail       = 0;
        reset_n      = 1'b0;
        cond_v       = 6'd0;
        out_ready    = 1'b0;
        overflow_clr = 1'b0;
        for (int i = 0; i < 6; i++) arg_v[i] = 32'd0;
        model_reset();

        // Reset state
        #2;
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.chan", 32'(out_chan), 32'd0);
        check("rst.data", out_data, 32'd0);
        check("rst.last", 32'(out_last), 32'd0);
        check("rst.ovf", 32'(overflow), 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        step(6'd0, 1'b1, 1'b0, "idle");

        // Two-beat record, sink always ready
        rand_args();
        arg_v[0] = 32'h80000000;
        arg_v[1] = 32'h00000013;
        step(6'b000011, 1'b1, 1'b0, "r031a");
        check("r031a.chan_k", 32'(out_chan), 32'd0);
        check("r031a.data_k", out_data, 32'h80000000);
        check("r031a.last_k", 32'(out_last), 32'd0);
        step(6'd0, 1'b1, 1'b0, "r031b");
        check("r031b.chan_k", 32'(out_chan), 32'd1);
        check("r031b.data_k", out_data, 32'h00000013);
        check("r031b.last_k", 32'(out_last), 32'd1);
        step(6'd0, 1'b1, 1'b0, "r031c");
        check("r031c.valid_k", 32'(out_valid), 32'd0);

        // Full record held by back-pressure, then released
        rand_args();
        arg_v[4] = 32'h001FFFFF;
        step(6'h3F, 1'b0, 1'b0, "r032hold");
        for (int i = 0; i < 4; i++) begin
            step(6'd0, 1'b0, 1'b0, "r032hold");
            check("r032hold.chan_k", 32'(out_chan), 32'd0);
        end
        for (int i = 0; i < 6; i++) begin
            step(6'd0, 1'b1, 1'b0, "r032run");
            if (i == 3) begin
                check("r032b4.chan_k", 32'(out_chan), 32'd4);
                check("r032b4.data_k", out_data, 32'h001FFFFF);
            end
        end
        check("r032end.valid_k", 32'(out_valid), 32'd0);

        // Six records into a four-deep FIFO with no sink
        for (int i = 0; i < 6; i++) begin
            rand_args();
            step(6'(i + 1), 1'b0, 1'b0, "r033fill");
        end
        check("r033.ovf_k", 32'(overflow), 32'd1);
`ifdef OBS_DROP_CNT_EN
        check("r033.dcnt_k", 32'(drop_cnt), 32'd2);
`endif
        drain("r033drain");
        step(6'd0, 1'b0, 1'b1, "r033clr");

        // Full FIFO, head's last beat handshakes while a record arrives
        for (int i = 0; i < DEPTH; i++) begin
            rand_args();
            step(6'b000001, 1'b0, 1'b0, "r034fill");
        end
        rand_args();
        step(6'b000100, 1'b1, 1'b0, "r034edge");
        check("r034.ovf_k", 32'(overflow), 32'd0);
        drain("r034drain");

        // Reset in the middle of a record
        rand_args();
        step(6'h3F, 1'b1, 1'b0, "r035a");
        step(6'd0, 1'b1, 1'b0, "r035b");
        step(6'd0, 1'b1, 1'b0, "r035c");
        cond_v  = 6'd0;
        reset_n = 1'b0;
        #1;
        model_reset();
        check("r035rst.valid", 32'(out_valid), 32'd0);
        check("r035rst.chan", 32'(out_chan), 32'd0);
        check("r035rst.data", out_data, 32'd0);
        check("r035rst.last", 32'(out_last), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) step(6'd0, 1'b1, 1'b0, "r035post");

        // Clear and drop in the same cycle
        for (int i = 0; i < DEPTH; i++) begin
            rand_args();
            step(6'b000010, 1'b0, 1'b0, "r036fill");
        end
        step(6'b000010, 1'b0, 1'b0, "r036drop");
        step(6'b000010, 1'b0, 1'b1, "r036clrdrop");
        check("r036.ovf_k", 32'(overflow), 32'd1);
`ifdef OBS_DROP_CNT_EN
        check("r036.dcnt_k", 32'(drop_cnt), 32'd1);
`endif
        step(6'd0, 1'b0, 1'b1, "r036clr");
        drain("r036drain");

        // Randomised traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [5:0] c;
            rand_args();
            c = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
            step(c, ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0), "rand");
        end
        drain("randdrain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
